icache_fetch: RTL and testbench

- Direct-mapped instruction cache between the core's fetch port (PC/ce out, 32-bit instruction in) and the shared byte-wide external memory.
- Returns a hit in the same cycle. On a miss, raises a stall request to ctrl and refills the 4-byte line one byte per granted cycle.
- Granted memory cycles are arbitrated against data-side traffic.

---
 rtl/icache_fetch_pkg.sv | 26 ++
 rtl/icache_fetch_mem.sv | 43 ++++
 rtl/icache_fetch.sv | 137 +++++++++++++
 tb/tb_icache_fetch.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_fetch_pkg.sv
// Shared types for the direct-mapped instruction cache: FSM encoding, debug view, byte-lane helper.
package icache_fetch_pkg;

    localparam int unsigned ICACHE_INDEX_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FILL  = 2'd2
    } icache_state_e;

    typedef struct packed {
        icache_state_e state;
        logic [2:0]    rq;
        logic [2:0]    rv;
    } icache_dbg_t;

    function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [7:0] data);
        logic [31:0] res;
        res = word;
        res[8*lane +: 8] = data;
        return res;
    endfunction

endpackage

// File: rtl/icache_fetch_mem.sv
// Valid/tag/data arrays: combinational read, synchronous write, synchronous clear of valid bits on reset.
module icache_fetch_mem #(
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned TAG_W   = 30 - INDEX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] i_rd_index,
    output logic               o_rd_valid,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic [31:0]        o_rd_data,
    input  logic               i_we,
    input  logic [INDEX_W-1:0] i_wr_index,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [31:0]        i_wr_data
);
    localparam int unsigned DEPTH = 2 ** INDEX_W;

    logic [DEPTH-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [DEPTH];
    logic [31:0]      r_data [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tag/data need no reset: nothing reads them while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped I-cache with byte-serial refill from shared memory.
// Optional hit/miss counters when ICACHE_PERF_CNT_EN is defined.
module icache_fetch
    import icache_fetch_pkg::*;
#(
    parameter int unsigned INDEX_W = ICACHE_INDEX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] addr_i,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic        valid_o,
    output logic        stall_req_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic [7:0]  mem_rdata_i,
`ifdef ICACHE_PERF_CNT_EN
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o,
`endif
    output icache_dbg_t dbg_o
);
    localparam int unsigned TAG_W = 30 - INDEX_W;

    icache_state_e r_state, w_state_nxt;
    logic [29:0]        r_line;
    logic [2:0]         r_rq, r_rv;
    logic [31:0]        r_buf;
    logic               r_gnt_d;
    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag, w_rd_tag;
    logic [31:0]        w_rd_data;
    logic               w_rd_valid, w_hit, w_miss, w_we;
    logic [1:0]         w_unused_addr_lo;

    assign w_index          = addr_i[INDEX_W+1:2];
    assign w_tag            = addr_i[31:INDEX_W+2];
    assign w_unused_addr_lo = addr_i[1:0];

    icache_fetch_mem #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_rd_index(w_index),
        .o_rd_valid(w_rd_valid),
        .o_rd_tag  (w_rd_tag),
        .o_rd_data (w_rd_data),
        .i_we      (w_we),
        .i_wr_index(r_line[INDEX_W-1:0]),
        .i_wr_tag  (r_line[29:INDEX_W]),
        .i_wr_data (r_buf)
    );

    assign w_hit  = ce_i & (r_state == ST_IDLE) & w_rd_valid & (w_rd_tag == w_tag);
    assign w_miss = ce_i & ~w_hit & ~flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_miss) w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (flush_i)                        w_state_nxt = ST_IDLE;
                else if (r_gnt_d && r_rv == 3'd3)   w_state_nxt = ST_FILL;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        valid_o     = w_hit;
        inst_o      = w_hit ? w_rd_data : 32'h0;
        stall_req_o = ce_i & ((r_state == ST_IDLE) ? w_miss : 1'b1);
        mem_req_o   = (r_state == ST_FETCH) & ~r_rq[2];
        mem_addr_o  = mem_req_o ? {r_line, r_rq[1:0]} : 32'h0;
        w_we        = (r_state == ST_FILL) & ~flush_i;
    end

    // A byte is expected only the cycle after a grant; flush discards any in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_line  <= '0;
            r_rq    <= '0;
            r_rv    <= '0;
            r_buf   <= '0;
            r_gnt_d <= 1'b0;
        end else begin
            r_gnt_d <= mem_req_o & mem_gnt_i & ~flush_i;
            case (r_state)
                ST_IDLE: begin
                    if (w_miss) begin
                        r_line <= addr_i[31:2];
                        r_rq   <= '0;
                        r_rv   <= '0;
                    end
                end
                ST_FETCH: begin
                    if (mem_req_o && mem_gnt_i) r_rq <= r_rq + 3'd1;
                    if (r_gnt_d) begin
                        r_buf <= put_byte(r_buf, r_rv[1:0], mem_rdata_i);
                        r_rv  <= r_rv + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbg_o = '{state: r_state, rq: r_rq, rv: r_rv};

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (valid_o) r_hit_cnt <= r_hit_cnt + 32'd1;
            if (r_state == ST_IDLE && w_state_nxt == ST_FETCH) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: byte-memory responder, expected-instruction queue, summary line.
module tb_icache_fetch;
    import icache_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst, ce_i, flush_i, mem_gnt_i;
    logic [31:0] addr_i;
    logic [7:0]  mem_rdata_i;
    logic [31:0] inst_o, mem_addr_o;
    logic        valid_o, stall_req_o, mem_req_o;
    icache_dbg_t dbg_o;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    icache_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce_i),
        .addr_i     (addr_i),
        .flush_i    (flush_i),
        .inst_o     (inst_o),
        .valid_o    (valid_o),
        .stall_req_o(stall_req_o),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_gnt_i  (mem_gnt_i),
        .mem_rdata_i(mem_rdata_i),
`ifdef ICACHE_PERF_CNT_EN
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o),
`endif
        .dbg_o      (dbg_o)
    );

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 8'h13;
            32'h0000_1001: return 8'h05;
            32'h0000_1002: return 8'h10;
            32'h0000_1003: return 8'h00;
            default:       return a[7:0] ^ {a[13:8], 2'b00} ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] line_word(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:2], 2'b00};
        return {mem_byte(b + 32'd3), mem_byte(b + 32'd2), mem_byte(b + 32'd1), mem_byte(b)};
    endfunction

    // Memory responder: a granted request returns its byte in the following cycle.
    initial begin
        logic        g;
        logic [31:0] a;
        mem_rdata_i = 8'h00;
        forever begin
            @(negedge clk);
            g = mem_req_o & mem_gnt_i;
            a = mem_addr_o;
            @(posedge clk);
            #1;
            mem_rdata_i = g ? mem_byte(a) : 8'($urandom_range(0, 255));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"},   32'(valid_o),     32'h0);
        check({tag, "_inst"},    inst_o,           32'h0);
        check({tag, "_stall"},   32'(stall_req_o), 32'h0);
        check({tag, "_req"},     32'(mem_req_o),   32'h0);
        check({tag, "_addr"},    mem_addr_o,       32'h0);
    endtask

    // One fetch at address a, held until valid_o; optional grant gap after gap_at grants.
    task automatic access(input logic [31:0] a, input int gap_at, input int gap_len, input int exp_lat);
        int          granted;
        int          gap_left;
        int          lat;
        logic [31:0] la;
        granted  = 0;
        gap_left = gap_len;
        lat      = -1;
        la       = {a[31:2], 2'b00};
        exp_q.push_back(line_word(a));
        for (int c = 0; c < 40 && lat < 0; c++) begin
            tick();
            ce_i      = 1'b1;
            addr_i    = a;
            flush_i   = 1'b0;
            mem_gnt_i = 1'b1;
            if (granted == gap_at && gap_left > 0) begin
                mem_gnt_i = 1'b0;
                gap_left--;
            end
            #3;
            if (c == 0) check("idle_no_req", 32'(mem_req_o), 32'h0);
            if (mem_req_o) begin
                check("mem_addr", mem_addr_o, {la[31:2], granted[1:0]});
                if (mem_gnt_i) granted++;
            end
            if (valid_o) begin
                lat = c;
                check("stall_on_hit", 32'(stall_req_o), 32'h0);
                check("inst", inst_o, exp_q.pop_front());
            end else begin
                check("stall_on_miss", 32'(stall_req_o), 32'h1);
            end
        end
        if (lat < 0) void'(exp_q.pop_front());
        check("latency", lat, exp_lat);
        check("req_count", granted, (exp_lat == 0) ? 32'd0 : 32'd4);
    endtask

    initial begin
        rst       = 1'b1;
        ce_i      = 1'b0;
        flush_i   = 1'b0;
        mem_gnt_i = 1'b0;
        addr_i    = 32'h0;

        tick();
        tick();
        rst = 1'b0;
        #3;
        check_quiet("reset");
        check("reset_state", 32'(dbg_o.state), 32'(ST_IDLE));

        // Cold miss, then hits (low address bits ignored).
        access(32'h0000_1000, -1, 0, 7);
        check("cold_word", line_word(32'h0000_1000), 32'h0010_0513);
        access(32'h0000_1000, -1, 0, 0);
        access(32'h0000_1002, -1, 0, 0);

        // Grant gap of two cycles after byte 1's request.
        access(32'h0000_2000, 2, 2, 9);

        // Same-index conflict.
        access(32'h0000_0000, -1, 0, 7);
        access(32'h0000_0100, -1, 0, 7);
        access(32'h0000_0000, -1, 0, 7);

        // Flush after two grants; a grant in the flush cycle returns a byte that must be dropped.
        tick();
        ce_i = 1'b1; addr_i = 32'h0000_3000; flush_i = 1'b0; mem_gnt_i = 1'b1;
        #3;
        check("flush_miss_stall", 32'(stall_req_o), 32'h1);
        tick(); #3;
        tick(); #3;
        check("flush_pre_req", 32'(mem_req_o), 32'h1);
        tick();
        flush_i = 1'b1;
        #3;
        check("flush_cycle_stall", 32'(stall_req_o), 32'h1);
        tick();
        flush_i = 1'b0; ce_i = 1'b0;
        #3;
        check("flush_req_drop", 32'(mem_req_o), 32'h0);
        check("flush_state", 32'(dbg_o.state), 32'(ST_IDLE));
        tick(); #3;
        check("flush_req_still", 32'(mem_req_o), 32'h0);
        access(32'h0000_3000, -1, 0, 7);

        // Flush in IDLE: a hit is reported, a miss is suppressed.
        access(32'h0000_1000, -1, 0, 7);
        tick();
        ce_i = 1'b1; addr_i = 32'h0000_1000; flush_i = 1'b1;
        #3;
        check("flush_idle_hit_valid", 32'(valid_o), 32'h1);
        check("flush_idle_hit_inst", inst_o, 32'h0010_0513);
        tick();
        addr_i = 32'h0000_5008;
        #3;
        check("flush_idle_miss_stall", 32'(stall_req_o), 32'h0);
        check("flush_idle_miss_valid", 32'(valid_o), 32'h0);
        tick();
        ce_i = 1'b0; flush_i = 1'b0;
        #3;
        check("flush_idle_no_refill", 32'(mem_req_o), 32'h0);

        // Reset during FETCH.
        tick();
        ce_i = 1'b1; addr_i = 32'h0000_4004; mem_gnt_i = 1'b1;
        #3;
        tick(); #3;
        check("rst_mid_req", 32'(mem_req_o), 32'h1);
        tick();
        rst = 1'b1; ce_i = 1'b0; mem_gnt_i = 1'b0;
        #3;
        tick();
        rst = 1'b0;
        #3;
        check_quiet("rst_mid");
        check("rst_mid_state", 32'(dbg_o.state), 32'(ST_IDLE));
`ifdef ICACHE_PERF_CNT_EN
        check("perf_hit_rst", hit_cnt_o, 32'd0);
        check("perf_miss_rst", miss_cnt_o, 32'd0);
`endif
        access(32'h0000_1000, -1, 0, 7);
        access(32'h0000_1000, -1, 0, 0);
        access(32'h0000_4004, -1, 0, 7);
        tick();
        ce_i = 1'b0;
        #3;
        check("end_idle_valid", 32'(valid_o), 32'h0);
`ifdef ICACHE_PERF_CNT_EN
        check("perf_hit", hit_cnt_o, 32'd3);
        check("perf_miss", miss_cnt_o, 32'd2);
`endif
        check("exp_q_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
